// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: routes one decoded instruction per cycle to its reservation
// station and allocates a ROB tag. An instruction that cannot dispatch is
// parked in a one-entry hold register and decode is stalled until it goes.
//
// Optional feature: define DISPATCH_PERF_EN to add the perf_stall_cyc and
// perf_disp_cnt saturating performance counters and their ports.
//
// state | meaning
// ------+-----------------------------------------------------------------
// RUN   | dispatch source is the decode inputs
// HOLD  | a blocked instruction sits in the hold register; decode stalled
module dispatch_ctrl #(
    parameter int ROB_DEPTH = 16,
    parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             dec_valid,
    input  logic [2:0]       dec_ftype,
    input  logic [1:0]       dec_mem_op,
    input  logic [4:0]       dec_rd,
    input  logic [4:0]       rs_ready,
    input  logic             rob_commit,
    output logic [4:0]       rs_push,
    output logic [TAG_W-1:0] disp_tag,
    output logic [4:0]       disp_rd,
    output logic             dec_stall,
    output logic [TAG_W:0]   rob_count
`ifdef DISPATCH_PERF_EN
    ,
    output logic [31:0]      perf_stall_cyc,
    output logic [31:0]      perf_disp_cnt
`endif
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_e;

    localparam logic [TAG_W:0] ROB_FULL = (TAG_W+1)'(ROB_DEPTH);

    state_e           state_q, state_d;
    logic [4:0]       hold_cls_q, hold_cls_d;
    logic [4:0]       hold_rd_q, hold_rd_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    logic [4:0] dec_cls;
    logic [4:0] src_cls;
    logic [4:0] src_rd;
    logic       disp_ok;
    logic       commit_ok;

    // Map decode fields to a one-hot class; memory ops override ftype, misc is 0.
    function automatic logic [4:0] class_of(input logic [2:0] ftype, input logic [1:0] mem_op);
        logic [4:0] cls;
        cls = 5'b00000;
        if (mem_op != 2'b00) begin
            cls = 5'b10000;
        end else begin
            case (ftype)
                3'd1:    cls = 5'b00001;
                3'd2:    cls = 5'b00010;
                3'd3:    cls = 5'b00100;
                3'd4,
                3'd5:    cls = 5'b01000;
                default: cls = 5'b00000;
            endcase
        end
        return cls;
    endfunction

    // Select dispatch source and decide whether it goes this cycle. Occupancy
    // is tested before this cycle's commit, so a full ROB never dispatches.
    // Outputs are forced quiet while reset is held.
    always_comb begin
        dec_cls   = dec_valid ? class_of(dec_ftype, dec_mem_op) : 5'b00000;
        src_cls   = (state_q == HOLD) ? hold_cls_q : dec_cls;
        src_rd    = (state_q == HOLD) ? hold_rd_q  : dec_rd;
        disp_ok   = rst_n && !flush && (count_q < ROB_FULL) && ((src_cls & rs_ready) != 5'b00000);
        commit_ok = rob_commit && (count_q != '0);
        rs_push   = disp_ok ? src_cls : 5'b00000;
        disp_rd   = disp_ok ? src_rd  : 5'b00000;
        disp_tag  = tail_q;
    end

    // Next-state logic for the RUN/HOLD FSM, hold register, tail and occupancy.
    always_comb begin
        state_d    = state_q;
        hold_cls_d = hold_cls_q;
        hold_rd_d  = hold_rd_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (flush) begin
            state_d    = RUN;
            hold_cls_d = 5'b00000;
            hold_rd_d  = 5'b00000;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if ((dec_cls != 5'b00000) && !disp_ok) begin
                        state_d    = HOLD;
                        hold_cls_d = dec_cls;
                        hold_rd_d  = dec_rd;
                    end
                end
                HOLD: begin
                    if (disp_ok) begin
                        state_d    = RUN;
                        hold_cls_d = 5'b00000;
                        hold_rd_d  = 5'b00000;
                    end
                end
                default: state_d = RUN;
            endcase
            if (disp_ok) begin
                tail_d = tail_q + TAG_W'(1);
            end
            if (disp_ok && !commit_ok) begin
                count_d = count_q + (TAG_W+1)'(1);
            end else if (!disp_ok && commit_ok) begin
                count_d = count_q - (TAG_W+1)'(1);
            end
        end
    end

    // State registers; reset discards any held instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            hold_cls_q <= 5'b00000;
            hold_rd_q  <= 5'b00000;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            hold_cls_q <= hold_cls_d;
            hold_rd_q  <= hold_rd_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    assign dec_stall = (state_q == HOLD);
    assign rob_count = count_q;

`ifdef DISPATCH_PERF_EN
    logic [31:0] perf_stall_q, perf_disp_q;

    // Saturating stall/dispatch counters; only reset clears them, not flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_disp_q  <= '0;
        end else begin
            if ((state_q == HOLD) && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (disp_ok && (perf_disp_q != 32'hFFFF_FFFF)) begin
                perf_disp_q <= perf_disp_q + 32'd1;
            end
        end
    end

    assign perf_stall_cyc = perf_stall_q;
    assign perf_disp_cnt  = perf_disp_q;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Testbench for dispatch_ctrl (ROB_DEPTH = 16). Expected dispatches are
// queued as stimulus is driven and popped on the cycle the DUT must push.
module tb_dispatch_ctrl;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       dec_valid;
    logic [2:0] dec_ftype;
    logic [1:0] dec_mem_op;
    logic [4:0] dec_rd;
    logic [4:0] rs_ready;
    logic       rob_commit;
    logic [4:0] rs_push;
    logic [3:0] disp_tag;
    logic [4:0] disp_rd;
    logic       dec_stall;
    logic [4:0] rob_count;
`ifdef DISPATCH_PERF_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_disp_cnt;
`endif

    dispatch_ctrl #(.ROB_DEPTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .dec_valid  (dec_valid),
        .dec_ftype  (dec_ftype),
        .dec_mem_op (dec_mem_op),
        .dec_rd     (dec_rd),
        .rs_ready   (rs_ready),
        .rob_commit (rob_commit),
        .rs_push    (rs_push),
        .disp_tag   (disp_tag),
        .disp_rd    (disp_rd),
        .dec_stall  (dec_stall),
        .rob_count  (rob_count)
`ifdef DISPATCH_PERF_EN
        ,
        .perf_stall_cyc (perf_stall_cyc),
        .perf_disp_cnt  (perf_disp_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] push;
        logic [3:0] tag;
        logic [4:0] rd;
    } disp_t;

    disp_t sb_q[$];
    int    total = 0;
    int    bad   = 0;
    logic [3:0] m_tail = 4'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] ft, input logic [1:0] mem,
                         input logic [4:0] rd, input logic [4:0] rdy,
                         input logic commit, input logic fl);
        dec_valid  = v;
        dec_ftype  = ft;
        dec_mem_op = mem;
        dec_rd     = rd;
        rs_ready   = rdy;
        rob_commit = commit;
        flush      = fl;
    endtask

    task automatic expect_disp(input logic [4:0] push, input logic [4:0] rd);
        disp_t e;
        e.push = push;
        e.tag  = m_tail;
        e.rd   = rd;
        sb_q.push_back(e);
        m_tail = m_tail + 4'd1;
    endtask

    // One clock: sample at the falling edge, then step past the next rising edge.
    task automatic cyc();
        disp_t e;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("push", {27'd0, rs_push}, {27'd0, e.push});
            chk("tag",  {28'd0, disp_tag}, {28'd0, e.tag});
            chk("rd",   {27'd0, disp_rd}, {27'd0, e.rd});
        end else begin
            chk("no_push", {27'd0, rs_push}, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 3'd1, 2'b00, 5'd9, 5'b11111, 1'b0, 1'b0);

        // reset holds everything quiet even with a dispatchable input present
        cyc();
        @(negedge clk);
        chk("rst_stall", {31'd0, dec_stall}, 32'd0);
        chk("rst_count", {27'd0, rob_count}, 32'd0);
        chk("rst_tag",   {28'd0, disp_tag}, 32'd0);
        chk("rst_rd",    {27'd0, disp_rd}, 32'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 3'd0, 2'b00, 5'd0, 5'b11111, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc();

        // basic alu dispatch
        drive(1'b1, 3'd1, 2'b00, 5'd3, 5'b11111, 1'b0, 1'b0);
        expect_disp(5'b00001, 5'd3);
        cyc();
        drive(1'b0, 3'd0, 2'b00, 5'd0, 5'b11111, 1'b0, 1'b0);
        chk("cnt_after_first", {27'd0, rob_count}, 32'd1);

        // mul blocked 3 cycles then released; decode inputs ignored while held
        drive(1'b1, 3'd2, 2'b00, 5'd7, 5'b11101, 1'b0, 1'b0);
        cyc();
        chk("stall_b", {31'd0, dec_stall}, 32'd1);
        drive(1'b1, 3'd1, 2'b00, 5'd9, 5'b11101, 1'b0, 1'b0);
        cyc();
        chk("stall_c", {31'd0, dec_stall}, 32'd1);
        cyc();
        chk("stall_d", {31'd0, dec_stall}, 32'd1);
        drive(1'b1, 3'd1, 2'b00, 5'd9, 5'b11111, 1'b0, 1'b0);
        expect_disp(5'b00010, 5'd7);
        cyc();
        drive(1'b0, 3'd0, 2'b00, 5'd0, 5'b11111, 1'b0, 1'b0);
        chk("stall_release", {31'd0, dec_stall}, 32'd0);
        chk("cnt_after_mul", {27'd0, rob_count}, 32'd2);

        // class mapping: mem override, jmp->brn, misc dropped, div, store
        drive(1'b1, 3'd1, 2'b10, 5'd4, 5'b11111, 1'b0, 1'b0);
        expect_disp(5'b10000, 5'd4);
        cyc();
        drive(1'b1, 3'd5, 2'b00, 5'd5, 5'b11111, 1'b0, 1'b0);
        expect_disp(5'b01000, 5'd5);
        cyc();
        drive(1'b1, 3'd0, 2'b00, 5'd6, 5'b11111, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 3'd7, 2'b00, 5'd6, 5'b11111, 1'b0, 1'b0);
        cyc();
        chk("misc_cnt", {27'd0, rob_count}, 32'd4);
        chk("misc_stall", {31'd0, dec_stall}, 32'd0);
        drive(1'b1, 3'd3, 2'b01, 5'd12, 5'b11111, 1'b0, 1'b0);
        expect_disp(5'b10000, 5'd12);
        cyc();
        drive(1'b1, 3'd3, 2'b00, 5'd13, 5'b11111, 1'b0, 1'b0);
        expect_disp(5'b00100, 5'd13);
        cyc();
        drive(1'b1, 3'd1, 2'b00, 5'd14, 5'b11111, 1'b0, 1'b0);
        expect_disp(5'b00001, 5'd14);
        cyc();
        chk("cnt7", {27'd0, rob_count}, 32'd7);

        // flush while holding at count 7
        drive(1'b1, 3'd2, 2'b00, 5'd15, 5'b11101, 1'b0, 1'b0);
        cyc();
        chk("hold_before_flush", {31'd0, dec_stall}, 32'd1);
        drive(1'b1, 3'd1, 2'b00, 5'd15, 5'b11111, 1'b0, 1'b1);
        cyc();
        m_tail = 4'd0;
        chk("flush_stall", {31'd0, dec_stall}, 32'd0);
        chk("flush_cnt", {27'd0, rob_count}, 32'd0);
        drive(1'b1, 3'd1, 2'b00, 5'd11, 5'b11111, 1'b0, 1'b0);
        expect_disp(5'b00001, 5'd11);
        cyc();

        // fill the ROB, block the 17th, commit frees one, tag wraps to 0
        drive(1'b0, 3'd0, 2'b00, 5'd0, 5'b11111, 1'b0, 1'b1);
        cyc();
        m_tail = 4'd0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 3'd1, 2'b00, 5'(i), 5'b11111, 1'b0, 1'b0);
            expect_disp(5'b00001, 5'(i));
            cyc();
        end
        chk("full_cnt", {27'd0, rob_count}, 32'd16);
        drive(1'b1, 3'd1, 2'b00, 5'd20, 5'b11111, 1'b0, 1'b0);
        cyc();
        chk("full_stall", {31'd0, dec_stall}, 32'd1);
        chk("full_cnt_hold", {27'd0, rob_count}, 32'd16);
        drive(1'b0, 3'd0, 2'b00, 5'd0, 5'b11111, 1'b1, 1'b0);
        cyc();
        chk("commit_cnt", {27'd0, rob_count}, 32'd15);
        drive(1'b0, 3'd0, 2'b00, 5'd0, 5'b11111, 1'b0, 1'b0);
        expect_disp(5'b00001, 5'd20);
        cyc();
        chk("wrap_cnt", {27'd0, rob_count}, 32'd16);
        chk("wrap_stall", {31'd0, dec_stall}, 32'd0);

        // commit on empty ROB, and dispatch+commit together
        drive(1'b0, 3'd0, 2'b00, 5'd0, 5'b11111, 1'b0, 1'b1);
        cyc();
        m_tail = 4'd0;
        drive(1'b0, 3'd0, 2'b00, 5'd0, 5'b11111, 1'b1, 1'b0);
        cyc();
        chk("underflow", {27'd0, rob_count}, 32'd0);
        drive(1'b1, 3'd4, 2'b00, 5'd21, 5'b11111, 1'b1, 1'b0);
        expect_disp(5'b01000, 5'd21);
        cyc();
        chk("disp_commit_empty", {27'd0, rob_count}, 32'd1);
        drive(1'b1, 3'd4, 2'b00, 5'd22, 5'b11111, 1'b1, 1'b0);
        expect_disp(5'b01000, 5'd22);
        cyc();
        chk("disp_commit_same", {27'd0, rob_count}, 32'd1);

        // reset in the middle of HOLD discards the held instruction
        drive(1'b1, 3'd2, 2'b00, 5'd23, 5'b11101, 1'b0, 1'b0);
        cyc();
        chk("pre_rst_stall", {31'd0, dec_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_stall", {31'd0, dec_stall}, 32'd0);
        chk("async_rst_cnt", {27'd0, rob_count}, 32'd0);
        drive(1'b0, 3'd0, 2'b00, 5'd0, 5'b11111, 1'b0, 1'b0);
        cyc();
        rst_n = 1'b1;
        m_tail = 4'd0;
        cyc();
        cyc();

        // 4 stall cycles and 5 dispatches for the perf counters
        drive(1'b1, 3'd2, 2'b00, 5'd24, 5'b11101, 1'b0, 1'b0);
        cyc();
        cyc();
        cyc();
        cyc();
        drive(1'b0, 3'd0, 2'b00, 5'd0, 5'b11111, 1'b0, 1'b0);
        expect_disp(5'b00010, 5'd24);
        cyc();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd1, 2'b00, 5'(25 + i), 5'b11111, 1'b0, 1'b0);
            expect_disp(5'b00001, 5'(25 + i));
            cyc();
        end
        drive(1'b0, 3'd0, 2'b00, 5'd0, 5'b11111, 1'b0, 1'b1);
        cyc();
        drive(1'b0, 3'd0, 2'b00, 5'd0, 5'b11111, 1'b0, 1'b0);
        cyc();
        chk("post_rst_cnt", {27'd0, rob_count}, 32'd0);
`ifdef DISPATCH_PERF_EN
        chk("perf_stall", perf_stall_cyc, 32'd4);
        chk("perf_disp", perf_disp_cnt, 32'd5);
`endif

        chk("sb_left", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
